// File: rtl/man_pkg.sv
// Shared Manchester line definitions: decoder state encoding and the bit polarity
// used by both the NRZ-to-Manchester encoder and the man_nrz decoder.
package man_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      MEAS  = 2'd1,
      TRACK = 2'd2
   } man_state_e;

   // A falling mid-bit edge carries a 1 (high-then-low).
   localparam logic MAN_FALL_IS_ONE = 1'b1;

endpackage

// File: rtl/man_edge_sync.sv
// Brings the asynchronous Manchester line into the clk domain through two flops and
// keeps a third flop so single-cycle rise/fall pulses can be formed.
module man_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic man_i,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= man_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;
   assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/man_nrz.sv
// Manchester-to-NRZ decoder: locks onto full-bit gaps between mid-bit edges and emits one
// NRZ bit per bit period. Define MAN_NRZ_ERR_EN to add the err output (loss of lock, glitches).
module man_nrz
   import man_pkg::*;
#(
   parameter int OSR = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic man,
   output logic nrz,
   output logic nrz_valid,
`ifdef MAN_NRZ_ERR_EN
   output logic err,
`endif
   output logic locked
);

   localparam int LO = 3*OSR/4;
   localparam int HI = 5*OSR/4;
   localparam int CW = $clog2(HI+2);

   localparam logic [CW-1:0] LO_C  = CW'(LO);
   localparam logic [CW-1:0] HI_C  = CW'(HI);
   localparam logic [CW-1:0] SAT_C = CW'(HI+1);

   logic          rise;
   logic          fall;
   logic          any_edge;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_now;
   logic          early;
   logic          late;
   logic          in_win;
   logic          dec_bit;

   man_state_e    state_q;
   logic          nrz_q;
   logic          valid_q;
   logic          locked_q;

`ifdef MAN_NRZ_ERR_EN
   logic [1:0]    glitch_q;
   logic          err_q;
`endif

   man_edge_sync u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .man_i  (man),
      .rise_o (rise),
      .fall_o (fall)
   );

   assign any_edge = rise | fall;
   // cnt_q excludes the current cycle, so cnt_now is the full edge-to-edge distance.
   assign cnt_now  = cnt_q + CW'(1);
   assign early    = cnt_now < LO_C;
   assign late     = cnt_now > HI_C;
   assign in_win   = !early && !late;
   assign dec_bit  = fall ? MAN_FALL_IS_ONE : ~MAN_FALL_IS_ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= HUNT;
         cnt_q    <= '0;
         nrz_q    <= 1'b0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
`ifdef MAN_NRZ_ERR_EN
         glitch_q <= 2'd0;
         err_q    <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
`ifdef MAN_NRZ_ERR_EN
         err_q   <= 1'b0;
`endif
         case (state_q)
            HUNT: begin
               if (any_edge) begin
                  state_q <= MEAS;
                  cnt_q   <= '0;
               end else if (cnt_q != SAT_C) begin
                  cnt_q <= cnt_now;
               end
            end

            MEAS: begin
               if (late) begin
                  state_q <= HUNT;
                  cnt_q   <= SAT_C;
               end else if (any_edge && early) begin
                  cnt_q <= '0;
               end else if (any_edge) begin
                  state_q  <= TRACK;
                  locked_q <= 1'b1;
                  cnt_q    <= '0;
                  nrz_q    <= dec_bit;
                  valid_q  <= 1'b1;
`ifdef MAN_NRZ_ERR_EN
                  glitch_q <= 2'd0;
`endif
               end else begin
                  cnt_q <= cnt_now;
               end
            end

            TRACK: begin
               if (late) begin
                  state_q  <= HUNT;
                  locked_q <= 1'b0;
                  cnt_q    <= SAT_C;
`ifdef MAN_NRZ_ERR_EN
                  err_q    <= 1'b1;
`endif
               end else if (any_edge && in_win) begin
                  cnt_q   <= '0;
                  nrz_q   <= dec_bit;
                  valid_q <= 1'b1;
`ifdef MAN_NRZ_ERR_EN
                  glitch_q <= 2'd0;
`endif
               end else begin
                  cnt_q <= cnt_now;
`ifdef MAN_NRZ_ERR_EN
                  // First early edge is the legal bit boundary; the second one is a glitch.
                  if (any_edge) begin
                     if (glitch_q == 2'd1) begin
                        err_q <= 1'b1;
                     end
                     if (glitch_q != 2'd2) begin
                        glitch_q <= glitch_q + 2'd1;
                     end
                  end
`endif
               end
            end

            default: begin
               state_q  <= HUNT;
               locked_q <= 1'b0;
               cnt_q    <= '0;
            end
         endcase
      end
   end

   assign nrz       = nrz_q;
   assign nrz_valid = valid_q;
   assign locked    = locked_q;
`ifdef MAN_NRZ_ERR_EN
   assign err       = err_q;
`endif

endmodule
